// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift-add step per clock.
// Latency IN_WIDTH+1 cycles from accepted start to bcd_valid; start is ignored while busy.
module bin_to_bcd_seq #(
   parameter int IN_WIDTH = 16,
   parameter int N_DIGITS = 5
) (
   input  logic                    clock_100Mhz,
   input  logic                    reset,
   input  logic                    start,
   input  logic [IN_WIDTH-1:0]     bin_in,
   output logic                    busy,
   output logic                    bcd_valid,
   output logic [4*N_DIGITS-1:0]   bcd_out,
   output logic                    ovf_4dig
);

   localparam int CNT_W = $clog2(IN_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IN_WIDTH-1:0]     shift_q, shift_d;
   logic [4*N_DIGITS-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [4*N_DIGITS-1:0]   bcd_q, bcd_d;
   logic                    ovf_q, ovf_d;

   logic [4*N_DIGITS-1:0]   adj;
   logic [4*N_DIGITS-1:0]   scratch_shl;
   logic [IN_WIDTH-1:0]     shift_shl;
   logic                    hi_nonzero;

   // Add-3 correction uses pre-shift digits, then the whole {scratch,shift} pair shifts left.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
      {scratch_shl, shift_shl} = {adj, shift_q} << 1;
      hi_nonzero = 1'b0;
      for (int i = 4; i < N_DIGITS; i++) begin
         hi_nonzero = hi_nonzero | (|scratch_shl[4*i +: 4]);
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               shift_d   = bin_in;
               scratch_d = '0;
               cnt_d     = '0;
               state_d   = CONV;
            end
         end
         CONV: begin
            shift_d   = shift_shl;
            scratch_d = scratch_shl;
            cnt_d     = cnt_q + 1'b1;
            // Publish on the final step so bcd_out and bcd_valid appear together in DONE.
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
               bcd_d   = scratch_shl;
               ovf_d   = hi_nonzero;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

   assign busy      = (state_q == CONV);
   assign bcd_valid = (state_q == DONE);
   assign bcd_out   = bcd_q;
   assign ovf_4dig  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: the driver queues expected conversions, the monitor checks each bcd_valid.
module tb_bin_to_bcd_seq;

   localparam int IN_WIDTH = 16;
   localparam int N_DIGITS = 5;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic [IN_WIDTH-1:0]   bin_in;
   logic                  busy;
   logic                  bcd_valid;
   logic [4*N_DIGITS-1:0] bcd_out;
   logic                  ovf_4dig;

   typedef struct {
      int unsigned val;
      int          acc_cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH), .N_DIGITS(N_DIGITS)) dut (
      .clock_100Mhz (clk),
      .reset        (reset),
      .start        (start),
      .bin_in       (bin_in),
      .busy         (busy),
      .bcd_valid    (bcd_valid),
      .bcd_out      (bcd_out),
      .ovf_4dig     (ovf_4dig)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [4*N_DIGITS-1:0] ref_bcd(input int unsigned v);
      logic [4*N_DIGITS-1:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      for (int i = 0; i < N_DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: bcd_valid high here will be sampled by edge cyc+1, which must be accept edge + 17.
   always @(negedge clk) begin
      if (!reset && bcd_valid) begin
         if (q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("bcd_out", 32'(bcd_out), 32'(ref_bcd(e.val)));
            check("ovf_4dig", 32'(ovf_4dig), 32'(e.val > 9999));
            check("latency", 32'(cyc + 1 - e.acc_cyc), 32'(IN_WIDTH + 1));
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (busy) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!bcd_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bcd_valid) check("valid_timeout", 32'd1, 32'd0);
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   // Called at a negedge with busy low, so the next rising edge accepts.
   task automatic issue(input int unsigned v);
      wait_idle();
      bin_in = IN_WIDTH'(v);
      start  = 1'b1;
      q.push_back('{val: v, acc_cyc: cyc + 1});
      @(negedge clk);
      start  = 1'b0;
      bin_in = IN_WIDTH'($urandom);
   endtask

   initial begin
      int t1;
      int t2;
      reset  = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(bcd_valid), 32'd0);
      check("rst_bcd_out", 32'(bcd_out), 32'd0);
      check("rst_ovf", 32'(ovf_4dig), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed boundary values
      issue(1234);
      drain();
      issue(0);
      issue(9999);
      issue(65535);
      issue(10000);
      issue(1);
      issue(65534);
      drain();

      // A start pulse during conversion must be ignored
      issue(1234);
      repeat (5) @(negedge clk);
      start  = 1'b1;
      bin_in = 16'd4321;
      @(negedge clk);
      start  = 1'b0;
      drain();
      repeat (20) @(negedge clk);

      // Start held high: back-to-back results one conversion period apart
      wait_idle();
      start  = 1'b1;
      bin_in = 16'd100;
      q.push_back('{val: 100, acc_cyc: cyc + 1});
      @(negedge clk);
      wait_valid();
      t1 = cyc;
      bin_in = 16'd200;
      q.push_back('{val: 200, acc_cyc: cyc + 1});
      @(negedge clk);
      wait_valid();
      t2 = cyc;
      start = 1'b0;
      check("b2b_spacing", 32'(t2 - t1), 32'(IN_WIDTH + 1));
      drain();

      // Reset mid-conversion aborts with no result
      issue(54321);
      repeat (7) @(negedge clk);
      reset = 1'b1;
      #2;
      q.delete();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_bcd_out", 32'(bcd_out), 32'd0);
      check("abort_valid", 32'(bcd_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      issue(42);
      drain();

      // Randomized sweep with random idle gaps
      for (int n = 0; n < 2000; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue($urandom_range(0, 65535));
      end
      drain();
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
